// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display that shares one MC14495-style decoder.
// Digits are driven in turn, separated by an all-off guard interval. New data is applied only at frame boundaries.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] hexs,
  input  logic [3:0]  points,
  input  logic [3:0]  blanks,
  output logic        busy,
  output logic [3:0]  hex_out,
  output logic        dp_out,
  output logic        le_out,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  localparam int MAX_CNT = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, DRIVE, GUARD} state_t;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [1:0]       nxt_idx;
  logic             nxt_tick, adv, apply_pt, do_apply, nxt_busy;
  logic [15:0]      act_hex, pend_hex, nxt_act_hex;
  logic [3:0]       act_pts, pend_pts, nxt_act_pts;
  logic [3:0]       act_blk, pend_blk, nxt_act_blk;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = digit_idx;
    nxt_tick  = 1'b0;
    adv       = 1'b0;
    apply_pt  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          nxt_state = DRIVE;
          nxt_cnt   = '0;
          nxt_idx   = 2'd0;
          apply_pt  = 1'b1;
        end
      end
      DRIVE: begin
        if (!en) begin
          nxt_state = IDLE;
        end else if (cnt == S_LAST) begin
          nxt_cnt = '0;
          if (GUARD_CYC == 0) adv = 1'b1;
          else                nxt_state = GUARD;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      GUARD: begin
        if (!en) begin
          nxt_state = IDLE;
        end else if (cnt == G_LAST) begin
          nxt_cnt   = '0;
          nxt_state = DRIVE;
          adv       = 1'b1;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase

    if (adv) begin
      nxt_idx = digit_idx + 2'd1;
      if (digit_idx == 2'd3) begin
        nxt_tick = 1'b1;
        apply_pt = 1'b1;
      end
    end

    // A load on the application cycle wins over the older pending copy.
    do_apply    = apply_pt && (busy || load);
    nxt_act_hex = act_hex;
    nxt_act_pts = act_pts;
    nxt_act_blk = act_blk;
    nxt_busy    = load ? 1'b1 : busy;
    if (do_apply) begin
      nxt_act_hex = load ? hexs   : pend_hex;
      nxt_act_pts = load ? points : pend_pts;
      nxt_act_blk = load ? blanks : pend_blk;
      nxt_busy    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_idx  <= 2'd0;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
      act_hex    <= '0;
      act_pts    <= '0;
      act_blk    <= '0;
      pend_hex   <= '0;
      pend_pts   <= '0;
      pend_blk   <= '0;
      an         <= 4'b1111;
      hex_out    <= 4'd0;
      dp_out     <= 1'b0;
      le_out     <= 1'b1;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      digit_idx  <= nxt_idx;
      frame_tick <= nxt_tick;
      busy       <= nxt_busy;
      act_hex    <= nxt_act_hex;
      act_pts    <= nxt_act_pts;
      act_blk    <= nxt_act_blk;
      if (load) begin
        pend_hex <= hexs;
        pend_pts <= points;
        pend_blk <= blanks;
      end
      // Decoder outputs are derived from next-cycle state so they stay aligned with the anodes.
      if (nxt_state == DRIVE) begin
        an      <= ~(4'b0001 << nxt_idx);
        hex_out <= nxt_act_hex[{nxt_idx, 2'b00} +: 4];
        dp_out  <= nxt_act_pts[nxt_idx];
        le_out  <= nxt_act_blk[nxt_idx];
      end else begin
        an     <= 4'b1111;
        le_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a guarded build and a no-guard build run side by side,
// compared every cycle against an arithmetic model of the scan timeline.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] hexs;
  logic [3:0]  points, blanks;

  logic        busy_a, dp_a, le_a, tick_a;
  logic [3:0]  hex_a, an_a;
  logic [1:0]  idx_a;
  logic        busy_b, dp_b, le_b, tick_b;
  logic [3:0]  hex_b, an_b;
  logic [1:0]  idx_b;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.SCAN_DIV(4), .GUARD_CYC(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .hexs(hexs), .points(points),
    .blanks(blanks), .busy(busy_a), .hex_out(hex_a), .dp_out(dp_a), .le_out(le_a),
    .an(an_a), .digit_idx(idx_a), .frame_tick(tick_a));

  seg_scan_ctrl #(.SCAN_DIV(4), .GUARD_CYC(0)) dut_ng (
    .clk(clk), .rst(rst), .en(en), .load(load), .hexs(hexs), .points(points),
    .blanks(blanks), .busy(busy_b), .hex_out(hex_b), .dp_out(dp_b), .le_out(le_b),
    .an(an_b), .digit_idx(idx_b), .frame_tick(tick_b));

  always #5 clk = ~clk;

  // Model state per build: index 0 = guard 1, index 1 = guard 0.
  bit          m_scan [2];
  int          m_t    [2];
  logic [15:0] m_act_hex [2], m_pend_hex [2];
  logic [3:0]  m_act_pts [2], m_pend_pts [2];
  logic [3:0]  m_act_blk [2], m_pend_blk [2];
  logic        m_busy [2], m_tick [2], m_le [2], m_dp [2];
  logic [3:0]  m_an [2], m_hex [2];
  logic [1:0]  m_idx [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int k);
    int s, g, p, f, d;
    bit app;
    s = 4;
    g = (k == 0) ? 1 : 0;
    p = s + g;
    f = 4 * p;
    if (rst) begin
      m_scan[k] = 0; m_t[k] = 0; m_busy[k] = 0; m_tick[k] = 0;
      m_act_hex[k] = 0; m_act_pts[k] = 0; m_act_blk[k] = 0;
      m_pend_hex[k] = 0; m_pend_pts[k] = 0; m_pend_blk[k] = 0;
      m_an[k] = 4'hF; m_hex[k] = 0; m_dp[k] = 0; m_le[k] = 1; m_idx[k] = 0;
      return;
    end
    app = 0;
    m_tick[k] = 0;
    if (en) begin
      if (!m_scan[k]) begin
        m_scan[k] = 1; m_t[k] = 0; app = 1;
      end else begin
        m_t[k]++;
        if (m_t[k] % f == 0) begin app = 1; m_tick[k] = 1; end
      end
    end else begin
      m_scan[k] = 0;
    end
    if (app && (m_busy[k] || load)) begin
      m_act_hex[k] = load ? hexs   : m_pend_hex[k];
      m_act_pts[k] = load ? points : m_pend_pts[k];
      m_act_blk[k] = load ? blanks : m_pend_blk[k];
      m_busy[k] = 0;
    end else if (load) begin
      m_busy[k] = 1;
    end
    if (load) begin
      m_pend_hex[k] = hexs; m_pend_pts[k] = points; m_pend_blk[k] = blanks;
    end
    if (m_scan[k]) begin
      d = (m_t[k] / p) % 4;
      m_idx[k] = 2'(d);
      if ((m_t[k] % p) >= s) begin
        m_an[k] = 4'hF; m_le[k] = 1;
      end else begin
        m_an[k]  = ~(4'b0001 << d);
        m_le[k]  = m_act_blk[k][d];
        m_dp[k]  = m_act_pts[k][d];
        m_hex[k] = m_act_hex[k][4*d +: 4];
      end
    end else begin
      m_an[k] = 4'hF; m_le[k] = 1;
    end
  endtask

  task automatic compare_all();
    chk("an_g1",   {12'd0, an_a},   {12'd0, m_an[0]});
    chk("hex_g1",  {12'd0, hex_a},  {12'd0, m_hex[0]});
    chk("dp_g1",   {15'd0, dp_a},   {15'd0, m_dp[0]});
    chk("le_g1",   {15'd0, le_a},   {15'd0, m_le[0]});
    chk("idx_g1",  {14'd0, idx_a},  {14'd0, m_idx[0]});
    chk("busy_g1", {15'd0, busy_a}, {15'd0, m_busy[0]});
    chk("tick_g1", {15'd0, tick_a}, {15'd0, m_tick[0]});
    chk("an_g0",   {12'd0, an_b},   {12'd0, m_an[1]});
    chk("hex_g0",  {12'd0, hex_b},  {12'd0, m_hex[1]});
    chk("dp_g0",   {15'd0, dp_b},   {15'd0, m_dp[1]});
    chk("le_g0",   {15'd0, le_b},   {15'd0, m_le[1]});
    chk("idx_g0",  {14'd0, idx_b},  {14'd0, m_idx[1]});
    chk("busy_g0", {15'd0, busy_b}, {15'd0, m_busy[1]});
    chk("tick_g0", {15'd0, tick_b}, {15'd0, m_tick[1]});
    chk("onehot_g1", {15'd0, ($countones(~an_a) <= 1)}, 16'd1);
    chk("onehot_g0", {15'd0, ($countones(~an_b) <= 1)}, 16'd1);
    chk("offle_g1",  {15'd0, (an_a != 4'hF) || le_a}, 16'd1);
    chk("offle_g0",  {15'd0, (an_b != 4'hF) || le_b}, 16'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] b);
    load = 1'b1; hexs = h; points = p; blanks = b;
    step();
    load = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; load = 1'b0; hexs = '0; points = '0; blanks = '0;
    step();
    step();
    chk("rst_an",   {12'd0, an_a},   16'h000F);
    chk("rst_le",   {15'd0, le_a},   16'd1);
    chk("rst_busy", {15'd0, busy_a}, 16'd0);
    chk("rst_idx",  {14'd0, idx_a},  16'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("idle_an", {12'd0, an_a}, 16'h000F);

    // Frame of 3A5F with alternating decimal points.
    do_load(16'h3A5F, 4'b0101, 4'b0000);
    chk("pend_busy", {15'd0, busy_a}, 16'd1);
    en = 1'b1;
    step();
    chk("first_an",  {12'd0, an_a},  16'h000E);
    chk("first_hex", {12'd0, hex_a}, 16'h000F);
    chk("first_dp",  {15'd0, dp_a},  16'd1);
    chk("applied",   {15'd0, busy_a}, 16'd0);
    for (int i = 0; i < 40; i++) step();

    // Mid-frame load while digit 1 is lit.
    n = 0;
    while (n < 100 && !(m_idx[0] == 2'd1 && m_an[0] == 4'b1101)) begin step(); n++; end
    chk("wait_d1", {15'd0, n < 100}, 16'd1);
    do_load(16'h1234, 4'b0000, 4'b0000);
    chk("mid_busy", {15'd0, busy_a}, 16'd1);
    n = 0;
    while (n < 100 && !tick_a) begin step(); n++; end
    chk("wrap_hex",  {12'd0, hex_a},  16'h0004);
    chk("wrap_busy", {15'd0, busy_a}, 16'd0);

    do_load(16'h1234, 4'b0000, 4'b0100);
    for (int i = 0; i < 45; i++) step();

    // Drop enable during digit 2, then restart.
    n = 0;
    while (n < 100 && !(m_idx[0] == 2'd2 && m_an[0] == 4'b1011)) begin step(); n++; end
    en = 1'b0;
    step();
    chk("drop_an", {12'd0, an_a}, 16'h000F);
    en = 1'b1;
    step();
    chk("restart_an",   {12'd0, an_a},   16'h000E);
    chk("restart_tick", {15'd0, tick_a}, 16'd0);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    chk("mid_rst_an",  {12'd0, an_a},  16'h000F);
    chk("mid_rst_hex", {12'd0, hex_a}, 16'h0000);
    chk("mid_rst_idx", {14'd0, idx_a}, 16'd0);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      load   = ($urandom_range(0, 9) == 0);
      hexs   = 16'($urandom);
      points = 4'($urandom);
      blanks = 4'($urandom);
      if ($urandom_range(0, 59) == 0) en = ~en;
      rst = ($urandom_range(0, 399) == 0);
      step();
      load = 1'b0;
      rst  = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
